// File: rtl/adc_window_ctrl_pkg.sv
// Shared definitions for the ADC integration-window controller.
//   DRAIN_CYCLES_DEFAULT : default settle time after the gate closes
//   SUM_W / COUNT_W      : widths of the adcsum accumulator and sample count
//   state_t              : controller FSM states
package adc_window_ctrl_pkg;

    localparam int unsigned DRAIN_CYCLES_DEFAULT = 2;
    localparam int unsigned SUM_W                = 32;
    localparam int unsigned COUNT_W              = 16;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StGate,
        StDrain,
        StLatch
    } state_t;

endpackage

// File: rtl/adc_window_ctrl_if.sv
// Result hand-off bus between the window controller and its consumer.
//   result_sum / result_count : captured accumulator and sample count
//   result_valid              : result held, awaiting acknowledge
//   result_ack                : consumer acknowledge
// master = controller side, slave = consumer side.
interface adc_window_ctrl_if;
    import adc_window_ctrl_pkg::*;

    logic [SUM_W-1:0]   result_sum;
    logic [COUNT_W-1:0] result_count;
    logic               result_valid;
    logic               result_ack;

    modport master (
        output result_sum,
        output result_count,
        output result_valid,
        input  result_ack
    );

    modport slave (
        input  result_sum,
        input  result_count,
        input  result_valid,
        output result_ack
    );

endinterface

// File: rtl/adcsum.sv
// Simple ADC accumulator: on each data_ready adds data to q and bumps count.
//   clk, sclr       : clock, synchronous active-high clear (wins over data_ready)
//   data_ready,data : sample strobe and value
//   q, count        : running sum and sample count (registered, 1-cycle latency)
module adcsum
    import adc_window_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               sclr,
    input  logic               data_ready,
    input  logic [15:0]        data,
    output logic [SUM_W-1:0]   q,
    output logic [COUNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (sclr) begin
            q     <= '0;
            count <= '0;
        end else if (data_ready) begin
            q     <= q + SUM_W'(data);
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/adc_window_ctrl.sv
// Integration-window controller in front of an adcsum accumulator.
// Opens a window on start, clears the accumulator, forwards adc_ready for a
// window measured in clocks (mode 0) or in samples (mode 1), waits for the
// accumulator pipeline to settle, then captures sum/count into a held result.
//   clk, sclr            : clock, synchronous active-high reset
//   start, abort         : open a window / drop the running window
//   mode, window_len     : window unit and length, captured on accepted start
//   adc_ready            : raw ADC strobe
//   sum_sclr             : clear to adcsum
//   sum_data_ready       : gated strobe to adcsum
//   sum_q, sum_count     : adcsum outputs
//   busy, overrun        : not idle / sticky unacknowledged-overwrite flag
//   res                  : result bus (sum, count, valid, ack)
module adc_window_ctrl
    import adc_window_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter int unsigned LEN_W        = 16
) (
    input  logic               clk,
    input  logic               sclr,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    input  logic [LEN_W-1:0]   window_len,
    input  logic               adc_ready,
    output logic               sum_sclr,
    output logic               sum_data_ready,
    input  logic [SUM_W-1:0]   sum_q,
    input  logic [COUNT_W-1:0] sum_count,
    output logic               busy,
    output logic               overrun,
    adc_window_ctrl_if.master  res
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
        DRAIN_W'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
    // With no drain time the gate goes straight to capture.
    localparam state_t AFTER_GATE = (DRAIN_CYCLES == 0) ? StLatch : StDrain;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic [SUM_W-1:0]     res_sum_q;
    logic [COUNT_W-1:0]   res_count_q;
    logic                 res_valid_q;
    logic                 overrun_q;
    logic                 running;

    assign running = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                    cnt_d   = window_len;
                    mode_d  = mode;
                end
            end
            StClear: begin
                if (cnt_q == '0) begin
                    state_d = AFTER_GATE;
                    drain_d = DRAIN_LOAD;
                end else begin
                    state_d = StGate;
                end
            end
            StGate: begin
                // Mode 0 counts clocks, mode 1 counts forwarded strobes.
                if (!mode_q || adc_ready) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = AFTER_GATE;
                        drain_d = DRAIN_LOAD;
                    end
                end
            end
            StDrain: begin
                if (drain_q == '0) begin
                    state_d = StLatch;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            StLatch: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort && running) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            drain_q     <= '0;
            res_sum_q   <= '0;
            res_count_q <= '0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            drain_q <= drain_d;
            if (state_q == StLatch && !abort) begin
                res_sum_q   <= sum_q;
                res_count_q <= sum_count;
                res_valid_q <= 1'b1;
                if (res_valid_q && !res.result_ack) begin
                    overrun_q <= 1'b1;
                end
            end else if (res_valid_q && res.result_ack) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    // Accumulator is cleared during reset, at window open, and on abort.
    assign sum_sclr       = sclr || (state_q == StClear) || (abort && running);
    assign sum_data_ready = (state_q == StGate) && adc_ready;
    assign busy           = running;
    assign overrun        = overrun_q;

    assign res.result_sum   = res_sum_q;
    assign res.result_count = res_count_q;
    assign res.result_valid = res_valid_q;

endmodule

// File: tb/tb_adc_window_ctrl.sv
// Directed bench: adc_window_ctrl driving a real adcsum, result bus via interface.
module tb_adc_window_ctrl;
    import adc_window_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        sclr = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mode = 1'b0;
    logic        adc_ready = 1'b0;
    logic [15:0] window_len = '0;
    logic [15:0] adc_data = '0;
    logic        sum_sclr, sum_data_ready, busy, overrun;
    logic [31:0] sum_q;
    logic [15:0] sum_count;
    int          n_checks = 0;
    int          n_fail = 0;

    adc_window_ctrl_if res_if ();

    adc_window_ctrl #(.DRAIN_CYCLES(2), .LEN_W(16)) u_dut (
        .clk(clk), .sclr(sclr), .start(start), .abort(abort), .mode(mode),
        .window_len(window_len), .adc_ready(adc_ready), .sum_sclr(sum_sclr),
        .sum_data_ready(sum_data_ready), .sum_q(sum_q), .sum_count(sum_count),
        .busy(busy), .overrun(overrun), .res(res_if)
    );

    adcsum u_sum (
        .clk(clk), .sclr(sum_sclr), .data_ready(sum_data_ready), .data(adc_data),
        .q(sum_q), .count(sum_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_window(input logic m, input logic [15:0] len);
        mode = m;
        window_len = len;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (res_if.result_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        sclr = 1'b1;
        tick();
        n_checks++; if (res_if.result_sum !== 32'd0) begin n_fail++; $display("FAIL rst_sum: got %0d want 0", res_if.result_sum); end
        n_checks++; if (res_if.result_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", res_if.result_count); end
        n_checks++; if (res_if.result_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", res_if.result_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (sum_data_ready !== 1'b0) begin n_fail++; $display("FAIL rst_sdr: got %b want 0", sum_data_ready); end
        n_checks++; if (sum_sclr !== 1'b1) begin n_fail++; $display("FAIL rst_sum_sclr: got %b want 1", sum_sclr); end
        sclr = 1'b0;
        tick();
        n_checks++; if (sum_sclr !== 1'b0) begin n_fail++; $display("FAIL idle_sum_sclr: got %b want 0", sum_sclr); end
    endtask

    task automatic test_mode1;
        int n;
        start_window(1'b1, 16'd5);
        // Changes after start must not affect the running window.
        mode = 1'b0;
        window_len = 16'd2;
        n_checks++; if (sum_sclr !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL m1_clear: got sclr=%b busy=%b want 1 1", sum_sclr, busy); end
        tick();
        for (int k = 0; k < 5; k++) begin
            repeat (9) tick();
            adc_ready = 1'b1;
            adc_data = 16'(2 + k);
            #1;
            n_checks++; if (sum_data_ready !== 1'b1) begin n_fail++; $display("FAIL m1_fwd%0d: got %b want 1", k, sum_data_ready); end
            tick();
            adc_ready = 1'b0;
        end
        adc_ready = 1'b1;
        #1;
        n_checks++; if (sum_data_ready !== 1'b0) begin n_fail++; $display("FAIL m1_drain_gate: got %b want 0", sum_data_ready); end
        adc_ready = 1'b0;
        wait_valid(n);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL m1_latency: got %0d want 3", n); end
        n_checks++; if (res_if.result_sum !== 32'd20) begin n_fail++; $display("FAIL m1_sum: got %0d want 20", res_if.result_sum); end
        n_checks++; if (res_if.result_count !== 16'd5) begin n_fail++; $display("FAIL m1_count: got %0d want 5", res_if.result_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL m1_busy: got %b want 0", busy); end
        res_if.result_ack = 1'b1;
        tick();
        res_if.result_ack = 1'b0;
        n_checks++; if (res_if.result_valid !== 1'b0) begin n_fail++; $display("FAIL m1_ack: got %b want 0", res_if.result_valid); end
        n_checks++; if (res_if.result_sum !== 32'd20) begin n_fail++; $display("FAIL m1_hold: got %0d want 20", res_if.result_sum); end
    endtask

    task automatic test_mode0;
        int n;
        int fwd;
        fwd = 0;
        start_window(1'b0, 16'd25);
        tick();
        for (int g = 0; g < 25; g++) begin
            adc_ready = (g % 10 == 0);
            adc_data = 16'(g + 1);
            #1;
            if (sum_data_ready === 1'b1) fwd++;
            tick();
        end
        adc_ready = 1'b1;
        #1;
        n_checks++; if (sum_data_ready !== 1'b0) begin n_fail++; $display("FAIL m0_gate_len: got %b want 0", sum_data_ready); end
        adc_ready = 1'b0;
        n_checks++; if (fwd !== 3) begin n_fail++; $display("FAIL m0_forwarded: got %0d want 3", fwd); end
        wait_valid(n);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL m0_latency: got %0d want 3", n); end
        n_checks++; if (res_if.result_count !== 16'd3) begin n_fail++; $display("FAIL m0_count: got %0d want 3", res_if.result_count); end
        n_checks++; if (res_if.result_sum !== 32'd33) begin n_fail++; $display("FAIL m0_sum: got %0d want 33", res_if.result_sum); end
        res_if.result_ack = 1'b1;
        tick();
        res_if.result_ack = 1'b0;
    endtask

    task automatic test_zero_len;
        int n;
        int fwd;
        fwd = 0;
        adc_ready = 1'b1;
        adc_data = 16'd50;
        start_window(1'b0, 16'd0);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            if (sum_data_ready === 1'b1) fwd++;
            tick();
            if (res_if.result_valid === 1'b1) begin
                n = i;
                break;
            end
        end
        adc_ready = 1'b0;
        n_checks++; if (fwd !== 0) begin n_fail++; $display("FAIL z_forwarded: got %0d want 0", fwd); end
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL z_latency: got %0d want 4", n); end
        n_checks++; if (res_if.result_sum !== 32'd0 || res_if.result_count !== 16'd0) begin n_fail++; $display("FAIL z_result: got %0d/%0d want 0/0", res_if.result_sum, res_if.result_count); end
        res_if.result_ack = 1'b1;
        tick();
        res_if.result_ack = 1'b0;
    endtask

    task automatic test_back_to_back;
        int n;
        // No ack between windows: second result overwrites, overrun sets.
        adc_ready = 1'b1;
        adc_data = 16'd7;
        start_window(1'b0, 16'd2);
        wait_valid(n);
        n_checks++; if (res_if.result_sum !== 32'd14) begin n_fail++; $display("FAIL b2b_first: got %0d want 14", res_if.result_sum); end
        adc_data = 16'd9;
        start_window(1'b0, 16'd1);
        repeat (5) tick();
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
        n_checks++; if (res_if.result_sum !== 32'd9 || res_if.result_count !== 16'd1) begin n_fail++; $display("FAIL b2b_second: got %0d/%0d want 9/1", res_if.result_sum, res_if.result_count); end
        n_checks++; if (res_if.result_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", res_if.result_valid); end
        adc_ready = 1'b0;
        test_reset();
        // Same pair, but ack coincides with the LATCH cycle of the second window.
        adc_ready = 1'b1;
        adc_data = 16'd7;
        start_window(1'b0, 16'd2);
        wait_valid(n);
        adc_data = 16'd9;
        start_window(1'b0, 16'd1);
        repeat (4) tick();
        res_if.result_ack = 1'b1;
        tick();
        res_if.result_ack = 1'b0;
        adc_ready = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ack_latch_overrun: got %b want 0", overrun); end
        n_checks++; if (res_if.result_valid !== 1'b1 || res_if.result_sum !== 32'd9) begin n_fail++; $display("FAIL ack_latch_result: got v=%b sum=%0d want v=1 sum=9", res_if.result_valid, res_if.result_sum); end
        res_if.result_ack = 1'b1;
        tick();
        res_if.result_ack = 1'b0;
        n_checks++; if (res_if.result_valid !== 1'b0) begin n_fail++; $display("FAIL ack_clear: got %b want 0", res_if.result_valid); end
    endtask

    task automatic test_abort;
        // Leave a held result (9/1) to prove abort does not touch it.
        adc_ready = 1'b1;
        adc_data = 16'd9;
        start_window(1'b0, 16'd1);
        repeat (5) tick();
        adc_ready = 1'b0;
        n_checks++; if (res_if.result_valid !== 1'b1 || res_if.result_sum !== 32'd9) begin n_fail++; $display("FAIL ab_pre: got v=%b sum=%0d want v=1 sum=9", res_if.result_valid, res_if.result_sum); end
        start_window(1'b1, 16'd3);
        tick();
        adc_ready = 1'b1;
        adc_data = 16'd4;
        tick();
        adc_ready = 1'b0;
        start = 1'b1;
        window_len = 16'd7;
        tick();
        start = 1'b0;
        n_checks++; if (sum_sclr !== 1'b0) begin n_fail++; $display("FAIL ab_start_ignored: got sclr=%b want 0", sum_sclr); end
        adc_ready = 1'b1;
        adc_data = 16'd5;
        #1;
        n_checks++; if (sum_data_ready !== 1'b1) begin n_fail++; $display("FAIL ab_still_gate: got %b want 1", sum_data_ready); end
        tick();
        adc_ready = 1'b0;
        n_checks++; if (sum_q !== 32'd9 || sum_count !== 16'd2) begin n_fail++; $display("FAIL ab_acc: got %0d/%0d want 9/2", sum_q, sum_count); end
        abort = 1'b1;
        #1;
        n_checks++; if (sum_sclr !== 1'b1) begin n_fail++; $display("FAIL ab_sclr: got %b want 1", sum_sclr); end
        tick();
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ab_idle: got busy=%b want 0", busy); end
        n_checks++; if (sum_q !== 32'd0) begin n_fail++; $display("FAIL ab_acc_clear: got %0d want 0", sum_q); end
        repeat (6) tick();
        n_checks++; if (res_if.result_valid !== 1'b1 || res_if.result_sum !== 32'd9 || res_if.result_count !== 16'd1) begin n_fail++; $display("FAIL ab_result_kept: got v=%b %0d/%0d want v=1 9/1", res_if.result_valid, res_if.result_sum, res_if.result_count); end
    endtask

    task automatic test_sclr_drain;
        adc_ready = 1'b1;
        adc_data = 16'd3;
        start_window(1'b0, 16'd1);
        tick();
        tick();
        adc_ready = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sd_pre_busy: got %b want 1", busy); end
        sclr = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        res_if.result_ack = 1'b1;
        tick();
        n_checks++; if (res_if.result_valid !== 1'b0 || res_if.result_sum !== 32'd0 || res_if.result_count !== 16'd0) begin n_fail++; $display("FAIL sd_result: got v=%b %0d/%0d want v=0 0/0", res_if.result_valid, res_if.result_sum, res_if.result_count); end
        n_checks++; if (busy !== 1'b0 || overrun !== 1'b0 || sum_data_ready !== 1'b0 || sum_sclr !== 1'b1) begin n_fail++; $display("FAIL sd_outputs: got busy=%b ovr=%b sdr=%b sclr=%b want 0 0 0 1", busy, overrun, sum_data_ready, sum_sclr); end
        sclr = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        res_if.result_ack = 1'b0;
        repeat (6) tick();
        n_checks++; if (res_if.result_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL sd_no_result: got v=%b busy=%b want 0 0", res_if.result_valid, busy); end
    endtask

    initial begin
        res_if.result_ack = 1'b0;
        test_reset();
        test_mode1();
        test_mode0();
        test_zero_len();
        test_back_to_back();
        test_abort();
        test_sclr_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
